// File: rtl/aes_key_sched_seq.sv
// Iterative AES key schedule: one expanded word per clock through a shared SubWord unit.
// Optional flat round-key bus enabled by defining KS_FULL_BUS_EN.
module aes_key_sched_seq #(
    parameter int unsigned nr = 10,
    parameter int unsigned nw = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [32*nw-1:0]    Key,
    output logic                busy,
    output logic                done,
    output logic                ready,
    input  logic                rk_req,
    input  logic [3:0]          rk_idx,
    output logic                rk_valid,
    output logic                rk_err,
    output logic [127:0]        rk
`ifdef KS_FULL_BUS_EN
    ,
    output logic [(nr+1)*128-1:0] full_key
`endif
);

    localparam int unsigned NWORDS = 4 * (nr + 1);

    // Entry x lives at bits [(255-x)*8 +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} state_t;

    state_t      state, stateNext;
    logic [5:0]  wordIdx;
    logic [2:0]  wrapCnt;
    logic [7:0]  rcon;
    logic [31:0] w [NWORDS];

    logic [31:0] prevWord, backWord, subIn, subOut, tWord, newWord;
    logic        lastWord, rdHit;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{8'd255 - x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

    assign lastWord = (wordIdx == 6'(NWORDS - 1));
    assign rdHit    = rk_req && (state == READY);

    always_comb begin
        prevWord = w[wordIdx - 6'd1];
        backWord = w[wordIdx - 6'(nw)];
        subIn    = (wrapCnt == 3'd0) ? {prevWord[23:0], prevWord[31:24]} : prevWord;
        subOut   = {sbox(subIn[31:24]), sbox(subIn[23:16]), sbox(subIn[15:8]), sbox(subIn[7:0])};
        if (wrapCnt == 3'd0)
            tWord = subOut ^ {rcon, 24'h0};
        else if (nw > 6 && wrapCnt == 3'd4)
            tWord = subOut;
        else
            tWord = prevWord;
        newWord = backWord ^ tWord;
    end

    always_comb begin
        stateNext = state;
        busy      = 1'b0;
        done      = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE:   if (start) stateNext = LOAD;
            LOAD: begin
                busy      = 1'b1;
                stateNext = EXPAND;
            end
            EXPAND: begin
                busy = 1'b1;
                if (lastWord) begin
                    done      = 1'b1;
                    stateNext = READY;
                end
            end
            READY: begin
                ready = 1'b1;
                if (start) stateNext = LOAD;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            wordIdx  <= '0;
            wrapCnt  <= '0;
            rcon     <= '0;
            rk_valid <= 1'b0;
            rk_err   <= 1'b0;
            rk       <= '0;
        end else begin
            state <= stateNext;
            if (state == LOAD) begin
                wordIdx <= 6'(nw);
                wrapCnt <= '0;
                rcon    <= 8'h01;
            end else if (state == EXPAND) begin
                wordIdx <= wordIdx + 6'd1;
                wrapCnt <= (wrapCnt == 3'(nw - 1)) ? '0 : wrapCnt + 3'd1;
                if (wrapCnt == 3'd0) rcon <= xtime(rcon);
            end
            // Reads sample the buffer before a same-cycle restart can overwrite it.
            rk_valid <= rdHit;
            rk_err   <= rdHit && (32'(rk_idx) > nr);
            if (rdHit) begin
                if (32'(rk_idx) > nr)
                    rk <= '0;
                else
                    rk <= {w[{rk_idx, 2'b00}], w[{rk_idx, 2'b01}],
                           w[{rk_idx, 2'b10}], w[{rk_idx, 2'b11}]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            for (int unsigned j = 0; j < nw; j++)
                w[j] <= Key[32*(nw-j)-1 -: 32];
        end else if (state == EXPAND) begin
            w[wordIdx] <= newWord;
        end
    end

`ifdef KS_FULL_BUS_EN
    for (genvar r = 0; r < nr + 1; r++) begin : g_fullKey
        assign full_key[r*128+127 -: 128] =
            ready ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    end
`endif

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Scoreboard bench for aes_key_sched_seq: AES-128 and AES-256 instances, FIPS-197 vectors.
module tb_aes_key_sched_seq;

    typedef struct packed {
        logic         err;
        logic [127:0] key;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0, start2 = 1'b0;
    logic [127:0] Key = '0;
    logic [255:0] key2 = '0;
    logic         busy, done, ready, rkValid, rkErr;
    logic         busy2, done2, ready2, rkValid2, rkErr2;
    logic         rkReq = 1'b0, rkReq2 = 1'b0;
    logic [3:0]   rkIdx = '0, rkIdx2 = '0;
    logic [127:0] rk, rk2;
`ifdef KS_FULL_BUS_EN
    logic [1407:0] fullKey;
    logic [1919:0] fullKey2;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t q1[$], q2[$];
    exp_t e1, e2;

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] R1_1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R2 [11] = '{
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5
    };

    always #5 clk = ~clk;

    aes_key_sched_seq dut (
        .clk(clk), .reset(reset), .start(start), .Key(Key),
        .busy(busy), .done(done), .ready(ready),
        .rk_req(rkReq), .rk_idx(rkIdx), .rk_valid(rkValid), .rk_err(rkErr), .rk(rk)
`ifdef KS_FULL_BUS_EN
        , .full_key(fullKey)
`endif
    );

    aes_key_sched_seq #(.nr(14), .nw(8)) dut256 (
        .clk(clk), .reset(reset), .start(start2), .Key(key2),
        .busy(busy2), .done(done2), .ready(ready2),
        .rk_req(rkReq2), .rk_idx(rkIdx2), .rk_valid(rkValid2), .rk_err(rkErr2), .rk(rk2)
`ifdef KS_FULL_BUS_EN
        , .full_key(fullKey2)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors pop one expectation per presented round key.
    always @(negedge clk) begin
        if (rkValid === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL aes128_unexpected_valid: got rk_valid=1 expected 0");
            end else begin
                e1 = q1.pop_front();
                chk("aes128_rk", rk, e1.key);
                chk("aes128_rk_err", 128'(rkErr), 128'(e1.err));
            end
        end
    end

    always @(negedge clk) begin
        if (rkValid2 === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL aes256_unexpected_valid: got rk_valid=1 expected 0");
            end else begin
                e2 = q2.pop_front();
                chk("aes256_rk", rk2, e2.key);
                chk("aes256_rk_err", 128'(rkErr2), 128'(e2.err));
            end
        end
    end

    task automatic req1(input logic [3:0] idx, input logic [127:0] exp, input logic err);
        rkReq = 1'b1;
        rkIdx = idx;
        q1.push_back('{err: err, key: exp});
        @(negedge clk);
    endtask

    task automatic req2(input logic [3:0] idx, input logic [127:0] exp, input logic err);
        rkReq2 = 1'b1;
        rkIdx2 = idx;
        q2.push_back('{err: err, key: exp});
        @(negedge clk);
    endtask

    // Start an AES-128 expansion; Key and a stray start are disturbed mid-run.
    task automatic expand1(input logic [127:0] k, input string name);
        int   n;
        logic readySeen;
        @(negedge clk);
        Key   = k;
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        n         = 1;
        readySeen = 1'b0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (ready === 1'b1) readySeen = 1'b1;
            if (n == 5)  Key = ~k;
            if (n == 10) start = 1'b1;
            if (n == 11) start = 1'b0;
        end
        chk({name, "_latency"}, 128'(n), 128'd41);
        chk({name, "_ready_before_done"}, 128'(readySeen), 128'd0);
        @(negedge clk);
        chk({name, "_ready"}, 128'(ready), 128'd1);
        chk({name, "_busy"}, 128'(busy), 128'd0);
    endtask

    task automatic resetChecks(input string name);
        chk({name, "_busy"}, 128'(busy), 128'd0);
        chk({name, "_done"}, 128'(done), 128'd0);
        chk({name, "_ready"}, 128'(ready), 128'd0);
        chk({name, "_rk_valid"}, 128'(rkValid), 128'd0);
        chk({name, "_rk_err"}, 128'(rkErr), 128'd0);
        chk({name, "_rk"}, rk, 128'd0);
`ifdef KS_FULL_BUS_EN
        chk({name, "_full_key_lo"}, fullKey[127:0], 128'd0);
        chk({name, "_full_key_hi"}, fullKey[1407:1280], 128'd0);
`endif
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        resetChecks("reset");
        reset = 1'b1;

        // AES-128, FIPS-197 appendix A key.
        expand1(K1, "k1");
`ifdef KS_FULL_BUS_EN
        chk("full_key_round0", fullKey[127:0], K1);
        chk("full_key_round10", fullKey[1407:1280], R1_10);
`endif
        req1(4'd1, R1_1, 1'b0);
        req1(4'd10, R1_10, 1'b0);
        req1(4'd12, 128'd0, 1'b1);
        req1(4'd10, R1_10, 1'b0);
        rkReq = 1'b0;
        @(negedge clk);

        // Restart with a read in the same cycle: read comes from the old schedule.
        Key   = K2;
        start = 1'b1;
        req1(4'd1, R1_1, 1'b0);
        start = 1'b0;
        rkReq = 1'b0;
        chk("restart_busy", 128'(busy), 128'd1);
        chk("restart_ready", 128'(ready), 128'd0);
        repeat (3) @(negedge clk);
        rkReq = 1'b1;
        rkIdx = 4'd5;
        @(negedge clk);
        rkReq = 1'b0;
        chk("expand_read_valid", 128'(rkValid), 128'd0);
        chk("expand_rk_hold", rk, R1_1);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("k2_ready_reached", 128'(ready), 128'd1);

        // Back-to-back reads of every round key.
        for (int i = 0; i < 11; i++) req1(4'(i), R2[i], 1'b0);
        rkReq = 1'b0;
        @(negedge clk);

        // Reset in the middle of an expansion, then expand a new key.
        @(negedge clk);
        Key   = K1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        resetChecks("midreset");
        reset = 1'b1;
        expand1(K2, "k2");
        req1(4'd1, R2[1], 1'b0);
        req1(4'd10, R2[10], 1'b0);
        req1(4'd0, K2, 1'b0);
        rkReq = 1'b0;
        @(negedge clk);

        // AES-256, FIPS-197 appendix A.3 style key 00..1f.
        key2   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n      = 1;
        while (done2 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("k256_latency", 128'(n), 128'd53);
        @(negedge clk);
        chk("k256_ready", 128'(ready2), 128'd1);
        req2(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b0);
        req2(4'd0, key2[255:128], 1'b0);
        req2(4'd15, 128'd0, 1'b1);
        rkReq2 = 1'b0;
        repeat (2) @(negedge clk);

        chk("aes128_pending", 128'(q1.size()), 128'd0);
        chk("aes256_pending", 128'(q2.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
